// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode / writeback bus of the scoreboarded register file.
// master: pipeline side (drives addresses, reservations, writebacks).
// slave : register file side (returns operands, busy flags, ack, error).
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ack;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;

  modport master (
    output rd_addr1, rd_addr2, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_ack, wr_err
  );

  modport slave (
    input  rd_addr1, rd_addr2, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_ack, wr_err
  );

endinterface

// File: rtl/regfile_busy_table.sv
// Pending-write scoreboard: one busy bit per register, reservation
// acknowledge, and the sticky error for writebacks to idle registers.
// A same-cycle release makes a register reservable, and a reservation
// overrides a release to the same register.
module regfile_busy_table
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b0
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 rsv_ack,
  output logic                 wr_err
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;
  logic             wr_err_r;
  logic             wr_err_nxt_s;
  logic             rsv_ack_s;
  logic             zero_rsv_s;
  logic             zero_wr_s;

  // Register 0 is hard-wired when ZERO_REG is set: its traffic is ignored.
  assign zero_rsv_s = ZERO_REG && (rsv_addr == {ADDR_W{1'b0}});
  assign zero_wr_s  = ZERO_REG && (wr_addr == {ADDR_W{1'b0}});

  // Acknowledge a reservation when the target is free or released this cycle.
  always_comb begin
    rsv_ack_s = 1'b0;
    if (!rsv_en) begin
      rsv_ack_s = 1'b0;
    end else if (zero_rsv_s) begin
      rsv_ack_s = 1'b1;
    end else if (!busy_r[rsv_addr] || (wr_en && (wr_addr == rsv_addr))) begin
      rsv_ack_s = 1'b1;
    end else begin
      rsv_ack_s = 1'b0;
    end
  end

  // Next busy vector and error flag: release first, then reservation wins.
  always_comb begin
    busy_nxt_s   = busy_r;
    wr_err_nxt_s = wr_err_r;
    if (wr_en && !zero_wr_s) begin
      busy_nxt_s[wr_addr] = 1'b0;
      wr_err_nxt_s        = wr_err_r | ~busy_r[wr_addr];
    end else begin
      wr_err_nxt_s = wr_err_r;
    end
    busy_nxt_s[rsv_addr] = busy_nxt_s[rsv_addr] | (rsv_ack_s & ~zero_rsv_s);
  end

  // Scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r   <= {DEPTH{1'b0}};
      wr_err_r <= 1'b0;
    end else begin
      busy_r   <= busy_nxt_s;
      wr_err_r <= wr_err_nxt_s;
    end
  end

  assign busy    = busy_r;
  assign rsv_ack = rsv_ack_s;
  assign wr_err  = wr_err_r;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read-port register file with a per-register pending-write scoreboard.
// Holds the data array and read muxing; busy bits live in regfile_busy_table.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to the
// read ports (data and a cleared busy flag).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b0
)(
  input logic                  clk,
  input logic                  reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] data_r [DEPTH];
  logic [DEPTH-1:0]  busy_s;
  logic              wr_live_s;
  logic [DATA_W-1:0] rd_data1_s;
  logic [DATA_W-1:0] rd_data2_s;
  logic              rd_busy1_s;
  logic              rd_busy2_s;
  logic              zero_rd1_s;
  logic              zero_rd2_s;

  regfile_busy_table #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .busy     (busy_s),
    .rsv_ack  (bus.rsv_ack),
    .wr_err   (bus.wr_err)
  );

  // Writes to a hard-wired register 0 are dropped.
  assign wr_live_s  = bus.wr_en && !(ZERO_REG && (bus.wr_addr == {ADDR_W{1'b0}}));
  assign zero_rd1_s = ZERO_REG && (bus.rd_addr1 == {ADDR_W{1'b0}});
  assign zero_rd2_s = ZERO_REG && (bus.rd_addr2 == {ADDR_W{1'b0}});

  // Data array, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_live_s) begin
      data_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read port 1: zero register, optional writeback bypass, else array.
  always_comb begin
    rd_data1_s = data_r[bus.rd_addr1];
    rd_busy1_s = busy_s[bus.rd_addr1];
    if (zero_rd1_s) begin
      rd_data1_s = {DATA_W{1'b0}};
      rd_busy1_s = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_live_s && (bus.wr_addr == bus.rd_addr1)) begin
      rd_data1_s = bus.wr_data;
      rd_busy1_s = 1'b0;
    end
`endif
    else begin
      rd_data1_s = data_r[bus.rd_addr1];
      rd_busy1_s = busy_s[bus.rd_addr1];
    end
  end

  // Read port 2: zero register, optional writeback bypass, else array.
  always_comb begin
    rd_data2_s = data_r[bus.rd_addr2];
    rd_busy2_s = busy_s[bus.rd_addr2];
    if (zero_rd2_s) begin
      rd_data2_s = {DATA_W{1'b0}};
      rd_busy2_s = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_live_s && (bus.wr_addr == bus.rd_addr2)) begin
      rd_data2_s = bus.wr_data;
      rd_busy2_s = 1'b0;
    end
`endif
    else begin
      rd_data2_s = data_r[bus.rd_addr2];
      rd_busy2_s = busy_s[bus.rd_addr2];
    end
  end

  assign bus.rd_data1 = rd_data1_s;
  assign bus.rd_data2 = rd_data2_s;
  assign bus.rd_busy1 = rd_busy1_s;
  assign bus.rd_busy2 = rd_busy2_s;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a vector table on the default
// instance, plus sequences for reset, bypass and a ZERO_REG=1 instance.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic clk;
  logic reset;

  int n_cmp;
  int n_fail;

  regfile_scoreboard_if bus ();
  regfile_scoreboard_if zbus ();

  regfile_scoreboard #(.ZERO_REG(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  regfile_scoreboard #(.ZERO_REG(1'b1)) dut_z (
    .clk   (clk),
    .reset (reset),
    .bus   (zbus.slave)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    reg_addr_t rd1;
    reg_addr_t rd2;
    logic      rsv_en;
    reg_addr_t rsv_addr;
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    reg_data_t e_d1;
    reg_data_t e_d2;
    logic      e_b1;
    logic      e_b2;
    logic      e_ack;
    logic      e_err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // rd1, rd2, rsv_en, rsv_addr, wr_en, wr_addr, wr_data | d1, d2, b1, b2, ack, err
    vecs[0]  = '{2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'd2, 2'd3, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'd2, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'd0, 2'd1, 1'b0, 2'd0, 1'b1, 2'd2, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'd2, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{2'd1, 2'd3, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'd2, 2'd3, 1'b1, 2'd1, 1'b1, 2'd1, 8'h77, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{2'd1, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 8'h77, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'd1, 2'd2, 1'b0, 2'd0, 1'b1, 2'd3, 8'h3C, 8'h77, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'd3, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{2'd3, 2'd2, 1'b0, 2'd0, 1'b1, 2'd1, 8'h11, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{2'd1, 2'd3, 1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 8'h11, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    bus.rd_addr1 = 2'd0;  bus.rd_addr2 = 2'd0;
    bus.rsv_en   = 1'b0;  bus.rsv_addr = 2'd0;
    bus.wr_en    = 1'b0;  bus.wr_addr  = 2'd0;  bus.wr_data  = 8'h00;
    zbus.rd_addr1 = 2'd0; zbus.rd_addr2 = 2'd3;
    zbus.rsv_en   = 1'b0; zbus.rsv_addr = 2'd0;
    zbus.wr_en    = 1'b0; zbus.wr_addr  = 2'd0; zbus.wr_data  = 8'h00;

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Table: inputs applied after the falling edge, outputs checked before the rising edge.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.rd_addr1 = vecs[i].rd1;
      bus.rd_addr2 = vecs[i].rd2;
      bus.rsv_en   = vecs[i].rsv_en;
      bus.rsv_addr = vecs[i].rsv_addr;
      bus.wr_en    = vecs[i].wr_en;
      bus.wr_addr  = vecs[i].wr_addr;
      bus.wr_data  = vecs[i].wr_data;
      #1;
      chk($sformatf("v%0d rd_data1", i), 32'(bus.rd_data1), 32'(vecs[i].e_d1));
      chk($sformatf("v%0d rd_data2", i), 32'(bus.rd_data2), 32'(vecs[i].e_d2));
      chk($sformatf("v%0d rd_busy1", i), 32'(bus.rd_busy1), 32'(vecs[i].e_b1));
      chk($sformatf("v%0d rd_busy2", i), 32'(bus.rd_busy2), 32'(vecs[i].e_b2));
      chk($sformatf("v%0d rsv_ack", i),  32'(bus.rsv_ack),  32'(vecs[i].e_ack));
      chk($sformatf("v%0d wr_err", i),   32'(bus.wr_err),   32'(vecs[i].e_err));
    end

    // Asynchronous reset mid-cycle with data, busy bits and error present.
    @(negedge clk);
    bus.rsv_en = 1'b0;
    bus.wr_en  = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 2'd0;
    #1;
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr1 = 2'(a);
      bus.rd_addr2 = 2'(3 - a);
      #1;
      chk($sformatf("rst rd_data1 a%0d", a), 32'(bus.rd_data1), 32'h0);
      chk($sformatf("rst rd_data2 a%0d", 3 - a), 32'(bus.rd_data2), 32'h0);
      chk($sformatf("rst rd_busy1 a%0d", a), 32'(bus.rd_busy1), 32'h0);
      chk($sformatf("rst rd_busy2 a%0d", 3 - a), 32'(bus.rd_busy2), 32'h0);
    end
    chk("rst wr_err", 32'(bus.wr_err), 32'h0);
    chk("rst rsv_ack", 32'(bus.rsv_ack), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    bus.rsv_en = 1'b0;

    // Writeback to read port in the same cycle.
    @(negedge clk);
    bus.rd_addr1 = 2'd0;
    bus.rd_addr2 = 2'd1;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 2'd1;
    bus.wr_data  = 8'h5A;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp same-cycle rd_data2", 32'(bus.rd_data2), 32'h5A);
`else
    chk("byp same-cycle rd_data2", 32'(bus.rd_data2), 32'h00);
`endif
    chk("byp same-cycle rd_busy2", 32'(bus.rd_busy2), 32'h0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    #1;
    chk("byp next-cycle rd_data2", 32'(bus.rd_data2), 32'h5A);
    chk("byp stray wr_err", 32'(bus.wr_err), 32'h1);

    // ZERO_REG instance: register 0 ignores reservations and writes.
    @(negedge clk);
    zbus.rd_addr1 = 2'd0;
    zbus.rsv_en   = 1'b1;
    zbus.rsv_addr = 2'd0;
    #1;
    chk("z rsv_ack r0", 32'(zbus.rsv_ack), 32'h1);
    @(negedge clk);
    zbus.rsv_en  = 1'b0;
    zbus.wr_en   = 1'b1;
    zbus.wr_addr = 2'd0;
    zbus.wr_data = 8'hFF;
    #1;
    chk("z busy r0 after rsv", 32'(zbus.rd_busy1), 32'h0);
    chk("z rd_data r0 during wr", 32'(zbus.rd_data1), 32'h00);
    @(negedge clk);
    zbus.wr_en    = 1'b0;
    zbus.rsv_en   = 1'b1;
    zbus.rsv_addr = 2'd3;
    #1;
    chk("z rd_data r0 after wr", 32'(zbus.rd_data1), 32'h00);
    chk("z rd_busy r0 after wr", 32'(zbus.rd_busy1), 32'h0);
    chk("z wr_err", 32'(zbus.wr_err), 32'h0);
    chk("z rsv_ack r3", 32'(zbus.rsv_ack), 32'h1);
    @(negedge clk);
    zbus.rsv_en = 1'b0;
    #1;
    chk("z rd_busy2 r3", 32'(zbus.rd_busy2), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port register file with a per-register pending-write scoreboard, replacing the fixed 4x8 register file in the processor datapath. Decode reads two operands combinationally and reserves a destination register at issue. Writeback writes the result and releases the reservation. Stall outputs tell the pipeline control when an operand is still pending.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 2, register address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, when 1 register 0 reads as 0 and ignores writes and reservations

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  read port 1 data
- rd_data2  output  DATA_W  read port 2 data
- rd_busy1  output  1  rd_addr1 has an outstanding reservation
- rd_busy2  output  1  rd_addr2 has an outstanding reservation
- rsv_en  input  1  request to reserve a destination register
- rsv_addr  input  ADDR_W  register to reserve
- rsv_ack  output  1  reservation accepted this cycle (combinational)
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback register
- wr_data  input  DATA_W  writeback data
- wr_err  output  1  sticky: a writeback targeted a non-busy register

## Operation
- Storage: DEPTH x DATA_W data array and DEPTH busy bits. Reads are combinational from the array.
- Write: when wr_en is high at a rising clk edge, data[wr_addr] <= wr_data and busy[wr_addr] <= 0. If busy[wr_addr] was already 0, the write still happens and wr_err sets to 1. wr_err stays set until reset.
- Reserve: rsv_ack = rsv_en & ~busy[rsv_addr], except that a same-cycle release counts as free:
  - rsv_ack = rsv_en & (~busy[rsv_addr] | (wr_en & wr_addr == rsv_addr)).
  - On ack, busy[rsv_addr] <= 1 at the clock edge. A rejected reservation changes no state; the requester holds and retries.
- Simultaneous write and reserve to the same register: the data is written and busy ends at 1 (the new reservation wins over the release).
- rd_busyN = busy[rd_addrN] as registered state. Same-cycle releases are not reflected unless bypass is compiled in.
- ZERO_REG=1: for address 0, rd_data reads 0, rd_busy reads 0, and rsv_ack equals rsv_en with busy never set. A write to address 0 is discarded and does not set wr_err.
- Reset: all data words, all busy bits and wr_err go to 0 immediately, regardless of clk. Consequently rd_data1/2 = 0, rd_busy1/2 = 0 and wr_err = 0. rsv_ack follows its combinational equation, which is 1 whenever rsv_en is high because all registers are free. A write or reserve coinciding with reset is lost.

## Timing
- Read latency 0 (combinational). Write and busy updates are visible after the next rising edge.
- Reserve-to-busy visible: 1 cycle. Writeback-to-data visible: 1 cycle, or 0 cycles with bypass.
- There is no combinational path from rd_addr to rsv_ack.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If wr_en is high and wr_addr == rd_addrN, rd_dataN = wr_data and rd_busyN = 0 in the same cycle.
  - If rsv_ack also targets that register, rd_busyN is still 0 for that cycle.
  - The bypass does not apply to address 0 when ZERO_REG=1.
- Undefined: reads return array contents only, and write-to-read takes 1 cycle.

## Structure
- Shared package regfile_pkg: default DATA_W/ADDR_W constants, typedefs reg_addr_t and reg_data_t.
- One sub-module, regfile_busy_table: busy bits, rsv_ack logic, wr_err. The top level holds the data array, read muxing and bypass.

## Test plan
- Reset then read: assert reset mid-run with data present, read all addresses -> rd_data=0x00, rd_busy=0, wr_err=0.
- Reserve r2, then read it: rsv r2 -> rsv_ack=1; next cycle rd_addr1=2 -> rd_busy1=1. Write r2=0xA5 -> following cycle rd_data1=0xA5, rd_busy1=0.
- Double reserve: reserve r1 (acked), then reserve r1 again -> rsv_ack=0, busy unchanged. In the same cycle as a write to r1 -> rsv_ack=1 and r1 busy=1 after the edge.
- Stray write: write r3=0x3C with r3 not busy -> r3=0x3C and wr_err=1, held through further writes until reset.
- ZERO_REG=1: reserve r0 and write r0=0xFF -> rd_data=0x00, rd_busy=0, wr_err=0.
- Bypass: with REGFILE_BYPASS_EN, write r1=0x5A while rd_addr2=1 -> rd_data2=0x5A in the same cycle. Without the macro, the old value is returned in that cycle and 0x5A after the edge.
